gpio_irq_ctrl: RTL

GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

---
 rtl/gpio_irq_ctrl.sv | 65 ++++++
 1 files changed

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: synchronised, debounced GPIO inputs with edge-triggered maskable interrupts
module gpio_irq_ctrl #(
  parameter int NUM_CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] gpio_in,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [1:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              reg_ack,
  output logic [NUM_CH-1:0] level,
  output logic              irq
);
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [15:0] cnt_q [NUM_CH];
  logic [NUM_CH-1:0] pending, mask, rise_en, fall_en, synced, toggle, set_ev, w1c;
  logic [31:0] rd_val;
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;
  assign synced = sync_q[SYNC_STAGES-1];
  assign set_ev = toggle & ((~level & rise_en) | (level & fall_en));
  assign w1c = reg_we && reg_addr == 2'd1 ? reg_wdata[NUM_CH-1:0] : '0;
  assign irq = |(pending & mask);
  always_comb begin
    toggle = '0;
    for (int i = 0; i < NUM_CH; i++) toggle[i] = synced[i] != level[i] && cnt_q[i] == CNT_MAX;
  end
  always_comb begin
    rd_val = '0;
    rd_val[NUM_CH-1:0] = reg_addr == 2'd0 ? level : reg_addr == 2'd1 ? pending : reg_addr == 2'd2 ? mask : rise_en;
    rd_val[16 +: NUM_CH] = reg_addr == 2'd3 ? fall_en : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      level <= '0;
      pending <= '0;
      mask <= '0;
      rise_en <= '0;
      fall_en <= '0;
      reg_ack <= 1'b0;
      reg_rdata <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= synced[i] == level[i] || toggle[i] ? '0 : cnt_q[i] + 16'd1;
      level <= level ^ toggle;
      pending <= (pending & ~w1c) | set_ev;
      if (reg_we && reg_addr == 2'd2) mask <= reg_wdata[NUM_CH-1:0];
      if (reg_we && reg_addr == 2'd3) begin
        rise_en <= reg_wdata[NUM_CH-1:0];
        fall_en <= reg_wdata[16 +: NUM_CH];
      end
      reg_ack <= reg_we || reg_re;
      reg_rdata <= reg_re ? rd_val : '0;
    end
  end
endmodule
